// File: rtl/exerion_hs_ram_arbiter.sv
// Exerion hiscore / CPU work-RAM arbiter.
// The Z80 normally owns the single-port work RAM. When the hiscore engine
// wants the RAM, the arbiter pauses the CPU and waits for its bus to stay
// idle for DRAIN_CYC clocks. It then hands the port to the hiscore side and
// gives it back through a one-clock release slot.
module exerion_hs_ram_arbiter #(
   parameter int          RAM_AW    = 11,
   parameter int          DW        = 8,
   parameter logic [15:0] RAM_BASE  = 16'h6000,
   parameter int          DRAIN_CYC = 3
) (
   input  logic              clkm_20MHZ,
   input  logic              RESET_n,
   input  logic [RAM_AW-1:0] cpu_addr,
   input  logic [DW-1:0]     cpu_din,
   input  logic              cpu_cs,
   input  logic              cpu_we,
   output logic [DW-1:0]     cpu_dout,
   input  logic [15:0]       hs_addr,
   input  logic [DW-1:0]     hs_din,
   input  logic              hs_we,
   input  logic              hs_intent,
   output logic [DW-1:0]     hs_dout,
   output logic              hs_grant,
   output logic              hs_oob,
   output logic              pause_req,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DW-1:0]     ram_din,
   output logic              ram_we,
   input  logic [DW-1:0]     ram_dout
);

   localparam int            CW        = $clog2(DRAIN_CYC + 1);
   localparam logic [CW-1:0] DRAIN_MAX = CW'(DRAIN_CYC);
   localparam logic [DW-1:0] DOUT_IDLE = {DW{1'b1}};

   typedef enum logic [1:0] {
      ST_CPU     = 2'd0,
      ST_PAUSE   = 2'd1,
      ST_GRANT   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc_s;
   logic          in_window_s;
   logic          rd_vld_q;
   logic          rd_oob_q;
   logic          hs_oob_q;
   logic [DW-1:0] hold_q;
   logic [DW-1:0] hs_dout_s;

   // The hiscore window is one RAM-sized, RAM-aligned block starting at RAM_BASE.
   assign in_window_s = (hs_addr[15:RAM_AW] == RAM_BASE[15:RAM_AW]);

   // Drain counter next value: saturates so it never wraps past DRAIN_CYC.
   assign cnt_inc_s = (cnt_q == DRAIN_MAX) ? cnt_q : cnt_q + CW'(1);

   // Next-state logic for ownership FSM and drain counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CPU: begin
            if (hs_intent) begin
               state_d = ST_PAUSE;
               cnt_d   = '0;
            end else begin
               state_d = ST_CPU;
            end
         end
         ST_PAUSE: begin
            if (!hs_intent) begin
               state_d = ST_CPU;
               cnt_d   = '0;
            end else if (cpu_cs) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s == DRAIN_MAX) begin
                  state_d = ST_GRANT;
               end else begin
                  state_d = ST_PAUSE;
               end
            end
         end
         ST_GRANT: begin
            if (!hs_intent) begin
               state_d = ST_RELEASE;
            end else begin
               state_d = ST_GRANT;
            end
         end
         ST_RELEASE: begin
            // Intent seen here is deliberately ignored; it is picked up in CPU.
            state_d = ST_CPU;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_CPU;
            cnt_d   = '0;
         end
      endcase
   end

   // State and drain counter registers.
   always_ff @(posedge clkm_20MHZ) begin
      if (!RESET_n) begin
         state_q <= ST_CPU;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // RAM port mux: ownership depends on state only, never on both strobes.
   always_comb begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = 1'b0;
      case (state_q)
         ST_CPU, ST_PAUSE: begin
            ram_we = RESET_n & cpu_cs & cpu_we;
         end
         ST_GRANT: begin
            ram_addr = hs_addr[RAM_AW-1:0] - RAM_BASE[RAM_AW-1:0];
            ram_din  = hs_din;
            ram_we   = RESET_n & hs_we & in_window_s;
         end
         ST_RELEASE: begin
            ram_we = 1'b0;
         end
         default: begin
            ram_we = 1'b0;
         end
      endcase
   end

   // Hiscore read tracking: remember whether last GRANT cycle was a read and in window.
   always_ff @(posedge clkm_20MHZ) begin
      if (!RESET_n) begin
         rd_vld_q <= 1'b0;
         rd_oob_q <= 1'b0;
         hs_oob_q <= 1'b0;
         hold_q   <= DOUT_IDLE;
      end else begin
         hold_q <= hs_dout_s;
         if (state_q == ST_GRANT) begin
            rd_vld_q <= ~hs_we;
            rd_oob_q <= ~in_window_s;
            hs_oob_q <= ~in_window_s;
         end else begin
            rd_vld_q <= 1'b0;
            rd_oob_q <= 1'b0;
            hs_oob_q <= hs_oob_q;
         end
      end
   end

   // Hiscore read data: fresh RAM word the clock after a read, otherwise held.
   always_comb begin
      hs_dout_s = hold_q;
      if (rd_vld_q) begin
         hs_dout_s = rd_oob_q ? DOUT_IDLE : ram_dout;
      end else begin
         hs_dout_s = hold_q;
      end
   end

   assign hs_dout   = hs_dout_s;
   assign hs_oob    = hs_oob_q;
   assign hs_grant  = (state_q == ST_GRANT);
   assign pause_req = (state_q == ST_PAUSE) || (state_q == ST_GRANT);
   assign cpu_dout  = ram_dout;

endmodule

// File: tb/tb_exerion_hs_ram_arbiter.sv
// Bench for exerion_hs_ram_arbiter with a behavioural 2 KB registered-read RAM.
module tb_exerion_hs_ram_arbiter;

   logic        clk;
   logic        RESET_n;
   logic [10:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_cs;
   logic        cpu_we;
   logic [7:0]  cpu_dout;
   logic [15:0] hs_addr;
   logic [7:0]  hs_din;
   logic        hs_we;
   logic        hs_intent;
   logic [7:0]  hs_dout;
   logic        hs_grant;
   logic        hs_oob;
   logic        pause_req;
   logic [10:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;
   logic [7:0]  ram_dout;

   logic [7:0]  mem [0:2047];
   logic [7:0]  exp_q [$];
   int          tests;
   int          fails;

   exerion_hs_ram_arbiter dut (
      .clkm_20MHZ(clk),
      .RESET_n   (RESET_n),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .cpu_cs    (cpu_cs),
      .cpu_we    (cpu_we),
      .cpu_dout  (cpu_dout),
      .hs_addr   (hs_addr),
      .hs_din    (hs_din),
      .hs_we     (hs_we),
      .hs_intent (hs_intent),
      .hs_dout   (hs_dout),
      .hs_grant  (hs_grant),
      .hs_oob    (hs_oob),
      .pause_req (pause_req),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout)
   );

   initial clk = 1'b0;
   always #25 clk = ~clk;

   // Work-RAM model: synchronous write, one-clock registered read.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Keep hs_intent high until hs_grant; returns clocks taken (0 if bound expires).
   task automatic wait_grant(output int n);
      n = 0;
      for (int i = 1; i <= 12 && n == 0; i++) begin
         tick();
         if (hs_grant === 1'b1) n = i;
      end
   endtask

   task automatic test_reset;
      RESET_n = 1'b0; hs_intent = 1'b1;
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h055; cpu_din = 8'hEE;
      tick(); tick();
      tests++; if (pause_req !== 1'b0) begin fails++; $display("FAIL reset_pause got %b want 0", pause_req); end
      tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL reset_grant got %b want 0", hs_grant); end
      tests++; if (hs_dout !== 8'hFF) begin fails++; $display("FAIL reset_hs_dout got %h want ff", hs_dout); end
      tests++; if (hs_oob !== 1'b0) begin fails++; $display("FAIL reset_oob got %b want 0", hs_oob); end
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
      tests++; if (mem[11'h055] !== 8'h00) begin fails++; $display("FAIL reset_no_write got %h want 00", mem[11'h055]); end
      cpu_cs = 1'b0; cpu_we = 1'b0; RESET_n = 1'b1;
      tick();
      tests++; if (pause_req !== 1'b1) begin fails++; $display("FAIL reset_exit_pause got %b want 1", pause_req); end
      hs_intent = 1'b0;
      tick();
      tests++; if (pause_req !== 1'b0) begin fails++; $display("FAIL pause_abort got %b want 0", pause_req); end
   endtask

   task automatic test_grant_timing;
      int n;
      hs_intent = 1'b1; cpu_cs = 1'b0;
      tick();
      tests++; if (pause_req !== 1'b1) begin fails++; $display("FAIL grant_pause_next got %b want 1", pause_req); end
      wait_grant(n);
      n = n + 1;
      tests++; if (n !== 4) begin fails++; $display("FAIL grant_latency got %0d want 4", n); end
      tests++; if (pause_req !== 1'b1) begin fails++; $display("FAIL grant_pause_held got %b want 1", pause_req); end
      hs_intent = 1'b0;
      tick();
      tests++; if (hs_grant !== 1'b0 || pause_req !== 1'b0) begin fails++; $display("FAIL grant_release got grant=%b pause=%b want 0/0", hs_grant, pause_req); end
      tick();
   endtask

   task automatic test_drain_restart;
      int n;
      hs_intent = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0;
      tick(); tick(); tick();
      cpu_cs = 1'b1;
      tick();
      cpu_cs = 1'b0;
      tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL drain_early got %b want 0", hs_grant); end
      wait_grant(n);
      tests++; if (n !== 3) begin fails++; $display("FAIL drain_restart got %0d idle clocks want 3", n); end
   endtask

   task automatic test_hs_rw;
      logic [15:0] a_tab [0:2];
      logic [7:0]  d_tab [0:2];
      logic [10:0] idx;
      logic [7:0]  exp;
      a_tab[0] = 16'h6010; d_tab[0] = 8'h5A;
      a_tab[1] = 16'h67FF; d_tab[1] = 8'hA5;
      a_tab[2] = 16'h6000; d_tab[2] = 8'hC3;
      for (int k = 0; k < 3; k++) begin
         idx = 11'(a_tab[k] - 16'h6000);
         hs_addr = a_tab[k]; hs_din = d_tab[k]; hs_we = 1'b1;
         tick();
         tests++; if (mem[idx] !== d_tab[k]) begin fails++; $display("FAIL hs_write[%0d] got %h want %h", k, mem[idx], d_tab[k]); end
         hs_we = 1'b0;
         exp_q.push_back(d_tab[k]);
         tick();
         exp = exp_q.pop_front();
         tests++; if (hs_dout !== exp) begin fails++; $display("FAIL hs_read[%0d] got %h want %h", k, hs_dout, exp); end
         tests++; if (hs_oob !== 1'b0) begin fails++; $display("FAIL hs_read_oob[%0d] got %b want 0", k, hs_oob); end
      end
   endtask

   task automatic test_oob;
      logic [7:0] exp;
      hs_addr = 16'h7000; hs_we = 1'b0;
      exp_q.push_back(8'hFF);
      tick();
      exp = exp_q.pop_front();
      tests++; if (hs_dout !== exp) begin fails++; $display("FAIL oob_read got %h want %h", hs_dout, exp); end
      tests++; if (hs_oob !== 1'b1) begin fails++; $display("FAIL oob_flag got %b want 1", hs_oob); end
      hs_din = 8'h77; hs_we = 1'b1;
      #1;
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL oob_write_we got %b want 0", ram_we); end
      tick();
      tests++; if (mem[11'h000] !== 8'hC3) begin fails++; $display("FAIL oob_write_mem got %h want c3", mem[11'h000]); end
      hs_addr = 16'h5FFF; hs_din = 8'h99;
      #1;
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL below_window_we got %b want 0", ram_we); end
      tick();
      hs_addr = 16'h6010; hs_we = 1'b0;
      exp_q.push_back(8'h5A);
      tick();
      exp = exp_q.pop_front();
      tests++; if (hs_dout !== exp) begin fails++; $display("FAIL oob_recover_read got %h want %h", hs_dout, exp); end
      tests++; if (hs_oob !== 1'b0) begin fails++; $display("FAIL oob_clear got %b want 0", hs_oob); end
   endtask

   task automatic test_release;
      hs_intent = 1'b0; hs_we = 1'b0;
      tick();
      tests++; if (hs_grant !== 1'b0 || pause_req !== 1'b0) begin fails++; $display("FAIL release_state got grant=%b pause=%b want 0/0", hs_grant, pause_req); end
      hs_addr = 16'h6020; hs_din = 8'hBB; hs_we = 1'b1;
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h020; cpu_din = 8'h33;
      hs_intent = 1'b1;
      #1;
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL release_ram_we got %b want 0", ram_we); end
      tick();
      tests++; if (pause_req !== 1'b0) begin fails++; $display("FAIL release_gap got pause=%b want 0", pause_req); end
      tests++; if (ram_we !== 1'b1 || ram_addr !== 11'h020) begin fails++; $display("FAIL cpu_back got we=%b addr=%h want 1/020", ram_we, ram_addr); end
      tests++; if (mem[11'h020] !== 8'h00) begin fails++; $display("FAIL release_hs_write got %h want 00", mem[11'h020]); end
      tick();
      tests++; if (mem[11'h020] !== 8'h33) begin fails++; $display("FAIL cpu_write_lands got %h want 33", mem[11'h020]); end
      tests++; if (pause_req !== 1'b1) begin fails++; $display("FAIL rerise_pause got %b want 1", pause_req); end
      cpu_cs = 1'b0; cpu_we = 1'b0;
      #1;
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL hs_we_in_pause got %b want 0", ram_we); end
      hs_intent = 1'b0; hs_we = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous;
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h030; cpu_din = 8'h44; hs_intent = 1'b1;
      tick();
      tests++; if (mem[11'h030] !== 8'h44) begin fails++; $display("FAIL simul_write got %h want 44", mem[11'h030]); end
      tests++; if (pause_req !== 1'b1) begin fails++; $display("FAIL simul_pause got %b want 1", pause_req); end
      cpu_cs = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic test_mid_grant_reset;
      int n;
      wait_grant(n);
      tests++; if (n == 0) begin fails++; $display("FAIL mgr_grant got timeout want grant"); end
      hs_addr = 16'h6010; hs_we = 1'b0;
      tick();
      RESET_n = 1'b0; hs_intent = 1'b0;
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h040; cpu_din = 8'h66;
      tick();
      tests++; if (hs_grant !== 1'b0 || pause_req !== 1'b0) begin fails++; $display("FAIL mgr_abort got grant=%b pause=%b want 0/0", hs_grant, pause_req); end
      tests++; if (hs_dout !== 8'hFF) begin fails++; $display("FAIL mgr_hs_dout got %h want ff", hs_dout); end
      tests++; if (ram_we !== 1'b0 || ram_addr !== 11'h040) begin fails++; $display("FAIL mgr_port got we=%b addr=%h want 0/040", ram_we, ram_addr); end
      RESET_n = 1'b1;
      tick();
      tests++; if (mem[11'h040] !== 8'h66) begin fails++; $display("FAIL mgr_cpu_write got %h want 66", mem[11'h040]); end
      cpu_cs = 1'b0; cpu_we = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0;
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      ram_dout = 8'h00;
      RESET_n = 1'b0; cpu_addr = 11'h000; cpu_din = 8'h00; cpu_cs = 1'b0; cpu_we = 1'b0;
      hs_addr = 16'h0000; hs_din = 8'h00; hs_we = 1'b0; hs_intent = 1'b0;
      test_reset();
      test_grant_timing();
      test_drain_restart();
      test_hs_rw();
      test_oob();
      test_release();
      test_simultaneous();
      test_mid_grant_reset();
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
